predecode_ibuf_tx: RTL and testbench
====================================

# predecode_ibuf_tx

Transmit side of the predecode-to-instruction-buffer interface. Takes one fetch block per handshake from the predecode pipeline and compacts its valid instruction slots to the low end of the bundle. It holds the compacted bundle under instruction-buffer backpressure and presents it with thermometer enables and a count. A two-entry skid (output register plus one spare) keeps the upstream `in_ready` registered, so no combinational path runs from the buffer's `full` to predecode.

## Interface
Parameters:
- `BLOCK_INST_SIZE`, default 8: instruction slots per fetch block; power of two.
- `FSQ_WIDTH`, default 5: FSQ index width.
- `OW`, default $clog2(BLOCK_INST_SIZE): slot offset width (derived).

Ports (clock and reset first):
- `clk`  in  1  clock; everything in this block uses it.
- `rst`  in  1  reset, synchronous and active-high.
- `redirect`  in  1  frontend flush; clears all held bundles.
- `in_valid`  in  1  predecode has a block.
- `in_ready`  out  1  block accepted when `in_valid & in_ready`.
- `in_inst`  in  BLOCK_INST_SIZE×32  raw slot instructions.
- `in_start`  in  OW  first valid slot.
- `in_end`  in  OW  last valid slot, inclusive.
- `in_skip`  in  BLOCK_INST_SIZE  slot is the upper half of a 32-bit instruction. Present only with the macro.
- `in_ipf`  in  BLOCK_INST_SIZE  per-slot page fault.
- `in_iam`  in  1  block misaligned.
- `in_fsq_idx`  in  FSQ_WIDTH  FSQ entry of the block.
- `out_en`  out  BLOCK_INST_SIZE  thermometer valid mask, LSB first.
- `out_num`  out  OW+1  popcount of `out_en`.
- `out_inst`  out  BLOCK_INST_SIZE×32  compacted instructions.
- `out_offset`  out  BLOCK_INST_SIZE×OW  original slot index of each output slot.
- `out_ipf`  out  BLOCK_INST_SIZE  compacted page-fault bits.
- `out_iam`, `out_fsq_idx`  out  1 / FSQ_WIDTH  block attributes.
- `ibuf_full`  in  1  buffer cannot take the current `out_num`.

## Operation
- Compaction, for output slot k and source slot s = `in_start`+k:
  - valid when s ≤ `in_end`;
  - `out_inst[k]` = `in_inst[s]`, `out_offset[k]` = s, `out_ipf[k]` = `in_ipf[s]`.
  - num = `in_end`−`in_start`+1, computed in OW+1 bits.
- Empty block: `in_end` < `in_start` gives num = 0. Such a block is accepted (handshake completes) and discarded; no state change.
- Output transfer: the bundle leaves at the clock edge where `out_en[0] & ~ibuf_full`. Its data is stable and unchanged while `out_en[0]` is high and not yet taken.
- State machine, on count of held bundles:
  - EMPTY (0), ONE (1, in output register), TWO (output register plus skid).
  - `in_ready` = (state != TWO), registered.
- Transitions (acc = nonempty block accepted, tx = output transfer):
  - EMPTY: acc → ONE, loads output register.
  - ONE: acc & tx → ONE, new block into output register. acc & ~tx → TWO, new block into skid. tx & ~acc → EMPTY.
  - TWO: tx → ONE, skid moves to output register. No acceptance is possible in TWO.
- Unused output slots (k ≥ num) drive 0 on `out_inst`, `out_offset` and `out_ipf`.
- `redirect`: next state is EMPTY and `out_en` = 0. A block presented in the redirect cycle is dropped. Redirect overrides tx and acc in the same cycle.
- `rst` behaves identically to `redirect` and takes priority over it.

## Timing
- Reset values: state EMPTY, `in_ready` = 1, `out_en` = 0, `out_num` = 0, all data outputs 0.
- Latency: accepted at edge N → visible on outputs after edge N (cycle N+1) when the block was EMPTY, or ONE with tx.
- Throughput: one block per cycle while `ibuf_full` stays 0.
- `in_ready` reflects the state after the previous edge. It depends on no input combinationally.
- `ibuf_full` is consumed combinationally, only to gate the output transfer.

## Configuration
- `PREDECODE_TX_RVC_EN`, defined:
  - `in_skip` port exists. Slots within [`in_start`,`in_end`] whose `in_skip` is set are removed.
  - Output slot k takes the k-th unskipped source slot, chosen by prefix count. `out_offset` stays the original slot index.
  - num = count of unskipped slots in range.
- Not defined:
  - No `in_skip` port.
  - Compaction is a pure contiguous shift by `in_start`.

## Test plan
- Reset then `in_start`=2, `in_end`=5, `ibuf_full`=0 → next cycle `out_en`=0x0F, `out_num`=4, `out_offset`={2,3,4,5}; EMPTY after transfer.
- Hold `ibuf_full`=1 and push 3 blocks back-to-back → first two held, `in_ready`=0 after second acceptance, third not accepted. Release full → bundles emerge in order on consecutive cycles.
- `in_start`=6, `in_end`=3 → handshake completes, `out_en` stays 0, state unchanged.
- State TWO and `redirect`=1 with `in_valid`=1 → next cycle `out_en`=0, `in_ready`=1, presented block lost.
- Full block `in_start`=0, `in_end`=7 → `out_num`=8 (carry bit set), `out_en`=0xFF.
- With `PREDECODE_TX_RVC_EN`: range 0..7, `in_skip`=0b0010_0010 → `out_num`=6, `out_offset`={0,2,3,4,6,7}.

Source files
------------

// File: rtl/predecode_ibuf_tx.sv
// Predecode -> instruction buffer transmit: compacts a fetch block, holds it in a 2-deep skid.
// Define PREDECODE_TX_RVC_EN to enable in_skip slot removal (compressed-instruction halves).
module predecode_ibuf_tx #(
    parameter int BLOCK_INST_SIZE = 8,
    parameter int FSQ_WIDTH       = 5,
    parameter int OW              = $clog2(BLOCK_INST_SIZE)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              redirect,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [BLOCK_INST_SIZE-1:0][31:0]  in_inst,
    input  logic [OW-1:0]                     in_start,
    input  logic [OW-1:0]                     in_end,
`ifdef PREDECODE_TX_RVC_EN
    input  logic [BLOCK_INST_SIZE-1:0]        in_skip,
`endif
    input  logic [BLOCK_INST_SIZE-1:0]        in_ipf,
    input  logic                              in_iam,
    input  logic [FSQ_WIDTH-1:0]              in_fsq_idx,
    output logic [BLOCK_INST_SIZE-1:0]        out_en,
    output logic [OW:0]                       out_num,
    output logic [BLOCK_INST_SIZE-1:0][31:0]  out_inst,
    output logic [BLOCK_INST_SIZE-1:0][OW-1:0] out_offset,
    output logic [BLOCK_INST_SIZE-1:0]        out_ipf,
    output logic                              out_iam,
    output logic [FSQ_WIDTH-1:0]              out_fsq_idx,
    input  logic                              ibuf_full
);

    localparam int N  = BLOCK_INST_SIZE;
    localparam int NW = OW + 1;

    typedef struct packed {
        logic [N-1:0]         en;
        logic [OW:0]          num;
        logic [N-1:0][31:0]   inst;
        logic [N-1:0][OW-1:0] off;
        logic [N-1:0]         ipf;
        logic                 iam;
        logic [FSQ_WIDTH-1:0] fsq;
    } bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e  state_q, state_d;
    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    bundle_t cmp;
    logic    rdy_q;
    logic    acc, tx;

`ifdef PREDECODE_TX_RVC_EN
    logic [OW:0] cnt;

    // Prefix-count placement: k-th surviving slot lands in output slot k.
    always_comb begin
        cmp = '0;
        cnt = '0;
        for (int s = 0; s < N; s++) begin
            if (OW'(s) >= in_start && OW'(s) <= in_end && !in_skip[s]) begin
                cmp.inst[cnt[OW-1:0]] = in_inst[s];
                cmp.off[cnt[OW-1:0]]  = OW'(s);
                cmp.ipf[cnt[OW-1:0]]  = in_ipf[s];
                cnt = cnt + NW'(1);
            end
        end
        cmp.num = cnt;
        for (int k = 0; k < N; k++) begin
            cmp.en[k] = NW'(k) < cmp.num;
        end
        cmp.iam = in_iam;
        cmp.fsq = in_fsq_idx;
    end
`else
    logic [OW:0] src;

    always_comb begin
        cmp = '0;
        src = '0;
        for (int k = 0; k < N; k++) begin
            src = {1'b0, in_start} + NW'(k);
            if (src <= {1'b0, in_end}) begin
                cmp.inst[k] = in_inst[src[OW-1:0]];
                cmp.off[k]  = src[OW-1:0];
                cmp.ipf[k]  = in_ipf[src[OW-1:0]];
            end
        end
        cmp.num = (in_end >= in_start)
                ? {1'b0, in_end} - {1'b0, in_start} + NW'(1)
                : '0;
        for (int k = 0; k < N; k++) begin
            cmp.en[k] = NW'(k) < cmp.num;
        end
        cmp.iam = in_iam;
        cmp.fsq = in_fsq_idx;
    end
`endif

    // Empty blocks complete the handshake but never enter the skid.
    assign acc = in_valid & rdy_q & (cmp.num != '0);
    assign tx  = out_q.en[0] & ~ibuf_full;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (redirect) begin
            state_d = EMPTY;
            out_d   = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        out_d   = cmp;
                    end
                end
                ONE: begin
                    if (acc && tx) begin
                        out_d = cmp;
                    end else if (acc) begin
                        state_d = TWO;
                        skid_d  = cmp;
                    end else if (tx) begin
                        state_d = EMPTY;
                        out_d   = '0;
                    end
                end
                TWO: begin
                    if (tx) begin
                        state_d = ONE;
                        out_d   = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    out_d   = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            rdy_q   <= (state_d != TWO);
        end
    end

    assign in_ready    = rdy_q;
    assign out_en      = out_q.en;
    assign out_num     = out_q.num;
    assign out_inst    = out_q.inst;
    assign out_offset  = out_q.off;
    assign out_ipf     = out_q.ipf;
    assign out_iam     = out_q.iam;
    assign out_fsq_idx = out_q.fsq;

endmodule

// File: tb/tb_predecode_ibuf_tx.sv
// Bench for predecode_ibuf_tx: vector table plus scoreboard of transmitted bundles.
// Build with PREDECODE_TX_RVC_EN to also exercise in_skip compaction.
module tb_predecode_ibuf_tx;

    logic                 clk = 1'b0;
    logic                 rst, redirect, in_valid, ibuf_full;
    logic                 in_ready;
    logic [7:0][31:0]     in_inst;
    logic [2:0]           in_start, in_end;
    logic [7:0]           in_skip;
    logic [7:0]           in_ipf;
    logic                 in_iam;
    logic [4:0]           in_fsq_idx;
    logic [7:0]           out_en;
    logic [3:0]           out_num;
    logic [7:0][31:0]     out_inst;
    logic [7:0][2:0]      out_offset;
    logic [7:0]           out_ipf;
    logic                 out_iam;
    logic [4:0]           out_fsq_idx;

    always #5 clk = ~clk;

    predecode_ibuf_tx dut (
        .clk(clk), .rst(rst), .redirect(redirect),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_start(in_start), .in_end(in_end),
`ifdef PREDECODE_TX_RVC_EN
        .in_skip(in_skip),
`endif
        .in_ipf(in_ipf), .in_iam(in_iam), .in_fsq_idx(in_fsq_idx),
        .out_en(out_en), .out_num(out_num), .out_inst(out_inst),
        .out_offset(out_offset), .out_ipf(out_ipf), .out_iam(out_iam),
        .out_fsq_idx(out_fsq_idx), .ibuf_full(ibuf_full)
    );

    typedef struct packed {
        logic [7:0]       en;
        logic [3:0]       num;
        logic [7:0][31:0] inst;
        logic [7:0][2:0]  off;
        logic [7:0]       ipf;
        logic             iam;
        logic [4:0]       fsq;
    } exp_t;

    typedef struct {
        logic [2:0] lo;
        logic [2:0] hi;
        logic [7:0] skip;
        logic [7:0] x_en;
        logic [3:0] x_num;
    } vec_t;

    vec_t tbl[$];
    exp_t sbq[$];
    exp_t pend;
    exp_t held;
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic exp_t model(input logic [2:0] lo, input logic [2:0] hi,
                                   input logic [7:0] skip,
                                   input logic [7:0][31:0] inst,
                                   input logic [7:0] ipf, input logic iam,
                                   input logic [4:0] fsq);
        exp_t e;
        int   n;
        e = '0;
        n = 0;
        for (int s = 0; s < 8; s++) begin
            if (s >= int'(lo) && s <= int'(hi) && !skip[s]) begin
                e.inst[n] = inst[s];
                e.off[n]  = 3'(s);
                e.ipf[n]  = ipf[s];
                e.en[n]   = 1'b1;
                n++;
            end
        end
        e.num = 4'(n);
        e.iam = iam;
        e.fsq = fsq;
        return e;
    endfunction

    task automatic check(input string nm, input logic [299:0] act,
                         input logic [299:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Scoreboard compare on the falling edge: a bundle is popped when it leaves.
    task automatic mon();
        exp_t act;
        act = {out_en, out_num, out_inst, out_offset, out_ipf, out_iam, out_fsq_idx};
        if (!rst && out_en[0]) begin
            if (sbq.size() == 0) begin
                check("unexpected_bundle", 300'(act), 300'(0));
            end else begin
                check("bundle", 300'(act), 300'(sbq[0]));
                if (!ibuf_full) void'(sbq.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] lo, input logic [2:0] hi,
                           input logic [7:0] skip);
        for (int i = 0; i < 8; i++) in_inst[i] = $urandom;
        in_ipf     = 8'($urandom);
        in_iam     = 1'($urandom);
        in_fsq_idx = 5'($urandom);
        in_start   = lo;
        in_end     = hi;
        in_skip    = skip;
        in_valid   = 1'b1;
        pend = model(lo, hi, skip, in_inst, in_ipf, in_iam, in_fsq_idx);
    endtask

    task automatic wait_acc(input string nm);
        bit a;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            a = in_ready;
            tick();
            if (a) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) check({nm, "_accept_timeout"}, 300'(0), 300'(1));
        else if (pend.num != 0) sbq.push_back(pend);
    endtask

    task automatic drain(input string nm);
        ibuf_full = 1'b0;
        for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
        check({nm, "_drain"}, 300'(sbq.size()), 300'(0));
        check({nm, "_idle"}, 300'({out_en, in_ready}), 300'({8'h00, 1'b1}));
    endtask

    initial begin
        tbl.push_back('{3'd2, 3'd5, 8'h00, 8'h0F, 4'd4});
        tbl.push_back('{3'd0, 3'd7, 8'h00, 8'hFF, 4'd8});
        tbl.push_back('{3'd6, 3'd3, 8'h00, 8'h00, 4'd0});
        tbl.push_back('{3'd3, 3'd3, 8'h00, 8'h01, 4'd1});
        tbl.push_back('{3'd0, 3'd0, 8'h00, 8'h01, 4'd1});
        tbl.push_back('{3'd7, 3'd7, 8'h00, 8'h01, 4'd1});
        tbl.push_back('{3'd1, 3'd6, 8'h00, 8'h3F, 4'd6});
        tbl.push_back('{3'd5, 3'd4, 8'h00, 8'h00, 4'd0});
        tbl.push_back('{3'd4, 3'd7, 8'h00, 8'h0F, 4'd4});
`ifdef PREDECODE_TX_RVC_EN
        tbl.push_back('{3'd0, 3'd7, 8'h22, 8'h3F, 4'd6});
        tbl.push_back('{3'd1, 3'd4, 8'h02, 8'h07, 4'd3});
        tbl.push_back('{3'd2, 3'd5, 8'h3C, 8'h00, 4'd0});
`endif

        rst = 1'b1;
        redirect = 1'b0;
        ibuf_full = 1'b0;
        in_valid = 1'b0;
        present(3'd0, 3'd7, 8'h00);
        @(posedge clk);
        #1;
        repeat (3) tick();
        check("rst_ctrl", 300'({in_ready, out_en, out_num}), 300'({1'b1, 8'h00, 4'd0}));
        check("rst_data", 300'({out_inst, out_offset, out_ipf, out_iam, out_fsq_idx}), 300'(0));
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        check("post_rst_idle", 300'({out_en, in_ready}), 300'({8'h00, 1'b1}));

        foreach (tbl[i]) begin
            present(tbl[i].lo, tbl[i].hi, tbl[i].skip);
            wait_acc($sformatf("vec%0d", i));
            check($sformatf("vec%0d_en_num", i), 300'({out_en, out_num}),
                  300'({tbl[i].x_en, tbl[i].x_num}));
            check($sformatf("vec%0d_ready", i), 300'(in_ready), 300'(1));
        end
        drain("table");

        ibuf_full = 1'b1;
        present(3'd1, 3'd3, 8'h00);
        wait_acc("bp_a");
        check("bp_ready_one", 300'(in_ready), 300'(1));
        present(3'd0, 3'd5, 8'h00);
        wait_acc("bp_b");
        check("bp_ready_two", 300'(in_ready), 300'(0));
        present(3'd4, 3'd6, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp_hold%0d", i), 300'({in_ready, out_num}), 300'({1'b0, 4'd3}));
        end
        ibuf_full = 1'b0;
        wait_acc("bp_c");
        drain("bp");

        ibuf_full = 1'b1;
        present(3'd3, 3'd6, 8'h00);
        wait_acc("emp_a");
        held = pend;
        present(3'd6, 3'd3, 8'h00);
        wait_acc("emp_blk");
        check("emp_state", 300'({in_ready, out_num, out_offset}),
              300'({1'b1, held.num, held.off}));
        drain("emp");

        ibuf_full = 1'b1;
        present(3'd0, 3'd7, 8'h00);
        wait_acc("rd_a");
        present(3'd1, 3'd2, 8'h00);
        wait_acc("rd_b");
        check("rd_two", 300'(in_ready), 300'(0));
        present(3'd2, 3'd5, 8'h00);
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        in_valid = 1'b0;
        sbq.delete();
        check("rd_flush", 300'({out_en, out_num, in_ready}), 300'({8'h00, 4'd0, 1'b1}));
        ibuf_full = 1'b0;
        repeat (3) tick();
        check("rd_lost", 300'({out_en, in_ready}), 300'({8'h00, 1'b1}));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
